flexbus_master: RTL and testbench
=================================

FLEXBUS_MASTER -- requirements
Module: flexbus_master

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, meaning extra data-phase cycles after the first (legal 0..15).
REQ-002 SHALL have parameter TA_TIMEOUT, default 15, meaning max data-phase cycles waiting for FB_TA when FLEXBUS_MASTER_TA_EN is defined (legal 1..15).
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 FB_CLK  input  1  bus and logic clock; all state changes on rising edge.
REQ-005 RST  input  1  reset.
REQ-006 req_valid  input  1  user transfer request.
REQ-007 req_ready  output  1  master accepts the request this cycle.
REQ-008 req_rw  input  1  1 = read, 0 = write.
REQ-009 req_addr  input  32  byte address, driven on the bus unmodified.
REQ-010 req_wdata  input  32  write data.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  32  read data; valid with rsp_valid on reads.
REQ-013 rsp_err  output  1  timeout flag; valid with rsp_valid.
REQ-014 FB_ALE  output  1  address latch enable, active high.
REQ-015 FB_CS  output  1  chip select, active low.
REQ-016 FB_RW  output  1  1 = read, 0 = write.
REQ-017 FB_AD  inout  32  multiplexed address/data.
REQ-018 FB_TA  input  1  transfer acknowledge, active low; present only when FLEXBUS_MASTER_TA_EN is defined.

Function
REQ-019 SHALL implement states IDLE, ADDR, DATA, HOLD.
REQ-020 IDLE: req_ready=1; on req_valid, latch req_rw/req_addr/req_wdata and go to ADDR the next cycle; otherwise stay in IDLE.
REQ-021 ADDR: exactly one cycle; FB_ALE=1, FB_CS=1, FB_RW=latched rw, FB_AD=latched address; then go to DATA.
REQ-022 DATA: FB_ALE=0, FB_CS=0, FB_RW held; write drives latched wdata on FB_AD, read leaves FB_AD at Z.
REQ-023 DATA SHALL last exactly 1+WAIT_STATES cycles, counted by a 4-bit down-counter loaded on entry to DATA.
REQ-024 Read: FB_AD SHALL be sampled into rsp_rdata at the rising edge that ends the last DATA cycle.
REQ-025 HOLD: exactly one cycle; FB_CS=1, FB_ALE=0, FB_AD=Z, FB_RW held; rsp_valid=1; then go to IDLE.
REQ-026 Transaction latency from acceptance to rsp_valid SHALL be 2+WAIT_STATES cycles.
REQ-027 Minimum accept-to-accept period SHALL be 4+WAIT_STATES cycles.
REQ-028 req_ready SHALL be 0 outside IDLE; requests presented then are not accepted and stay pending.
REQ-029 rsp_rdata SHALL hold its value until the next read completes; it SHALL be unchanged on writes.
REQ-030 rsp_err SHALL be 0 unless REQ-038 applies.
REQ-031 FB_AD SHALL never be driven in HOLD or IDLE, guaranteeing one turnaround cycle before the next ADDR.

Reset
REQ-032 While RST=1, from any state, asynchronously: state=IDLE, FB_ALE=0, FB_CS=1, FB_RW=1, FB_AD=Z, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, counter=0.
REQ-033 Reset asserted mid-transaction SHALL abort it with no rsp_valid.
REQ-034 req_ready SHALL rise in the first cycle after RST deasserts.

Configuration
REQ-035 Macro FLEXBUS_MASTER_TA_EN SHALL select acknowledge-terminated transfers.
REQ-036 Without the macro: fixed-length DATA per REQ-023; FB_TA port absent; rsp_err is constant 0.
REQ-037 With the macro: DATA ends on the first cycle FB_TA=0, sampled at the rising edge; WAIT_STATES is ignored.
REQ-038 With the macro: if FB_TA stays 1 for TA_TIMEOUT DATA cycles, go to HOLD with rsp_err=1; rsp_rdata is left unchanged.

Structure
REQ-039 Package flexbus_pkg SHALL hold the state enum, idle bus constants (ALE=0, CS=1, RW=1), and the 4-bit counter width.
REQ-040 Sub-module flexbus_wait_ctr SHALL implement the loadable down-counter with done flag; everything else SHALL be inline.

Verification
REQ-041 Write, WAIT_STATES=1, addr 0x60000004, data 0x12345678 -> bus shows ADDR with 0x60000004, DATA 2 cycles with 0x12345678, RW=0; rsp_valid 3 cycles after accept; rsp_err=0.
REQ-042 Read, WAIT_STATES=1, addr 0x60000008, slave model returns 0xDEADBEEF -> FB_AD Z in DATA; rsp_rdata=0xDEADBEEF with rsp_valid.
REQ-043 req_valid held high continuously, WAIT_STATES=0 -> accepts exactly every 4 cycles; FB_AD Z in every HOLD cycle.
REQ-044 RST pulsed during second DATA cycle of a write -> FB_CS=1 and FB_AD=Z immediately; no rsp_valid; next request completes normally.
REQ-045 FLEXBUS_MASTER_TA_EN, FB_TA low in 3rd DATA cycle -> HOLD next cycle; rsp_err=0.
REQ-046 FLEXBUS_MASTER_TA_EN, FB_TA never asserted, TA_TIMEOUT=4 -> HOLD after 4 DATA cycles with rsp_err=1.

Source files
------------

// File: rtl/flexbus_pkg.sv
// Shared types and constants for the FlexBus master.
// Optional feature macro: FLEXBUS_MASTER_TA_EN (acknowledge-terminated transfers).
package flexbus_pkg;

    // Bus sequencer states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_HOLD
    } fb_state_t;

    // Bus levels driven whenever no transfer is in progress
    localparam logic IDLE_ALE = 1'b0;
    localparam logic IDLE_CS  = 1'b1;
    localparam logic IDLE_RW  = 1'b1;

    // Width of the data-phase down-counter
    localparam int CTR_W = 4;

    // Latched user request
    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
    } fb_req_t;

    // Truncate an integer cycle count to the counter width
    function automatic logic [CTR_W-1:0] ctr_val(input int n);
        ctr_val = n[CTR_W-1:0];
    endfunction

endpackage

// File: rtl/flexbus_wait_ctr.sv
// Loadable down-counter timing the FlexBus data phase; done flags zero.
module flexbus_wait_ctr
    import flexbus_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CTR_W-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [CTR_W-1:0] cnt;

    // Load has priority; decrement saturates at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/flexbus_master.sv
// FlexBus master: one multiplexed address/data transfer per request.
// Sequence is ADDR (1 cycle), DATA (fixed or acknowledge-terminated), HOLD (1 cycle).
// Optional feature macro: FLEXBUS_MASTER_TA_EN -- DATA ends on FB_TA low, with timeout.
module flexbus_master
    import flexbus_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int TA_TIMEOUT  = 15
) (
    input  logic        FB_CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        FB_ALE,
    output logic        FB_CS,
    output logic        FB_RW,
    inout  wire  [31:0] FB_AD
`ifdef FLEXBUS_MASTER_TA_EN
    ,
    input  logic        FB_TA
`endif
);

`ifdef FLEXBUS_MASTER_TA_EN
    localparam bit USE_TA = 1'b1;
`else
    localparam bit USE_TA = 1'b0;
`endif

    // DATA lasts load value + 1 cycles (or until acknowledge when enabled)
    localparam logic [CTR_W-1:0] LOAD_VAL = USE_TA ? ctr_val(TA_TIMEOUT - 1) : ctr_val(WAIT_STATES);

    fb_state_t   state, state_nxt;
    fb_req_t     req_q;
    logic        accept;
    logic        ctr_done;
    logic        data_end;
    logic        timeout;
    logic        ready_c;
    logic        rsp_c;
    logic        ad_oe;
    logic [31:0] ad_out;

    flexbus_wait_ctr u_wait_ctr (
        .clk      (FB_CLK),
        .rst      (RST),
        .load     (state == ST_ADDR),
        .load_val (LOAD_VAL),
        .dec      (state == ST_DATA),
        .done     (ctr_done)
    );

`ifdef FLEXBUS_MASTER_TA_EN
    // Acknowledge wins over a timeout landing on the same cycle
    assign data_end = (state == ST_DATA) && (!FB_TA || ctr_done);
    assign timeout  = (state == ST_DATA) && FB_TA && ctr_done;
`else
    assign data_end = (state == ST_DATA) && ctr_done;
    assign timeout  = 1'b0;
`endif

    assign accept = (state == ST_IDLE) && req_valid;

    // State register
    always_ff @(posedge FB_CLK or posedge RST) begin
        if (RST)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next state and bus outputs
    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        rsp_c     = 1'b0;
        FB_ALE    = IDLE_ALE;
        FB_CS     = IDLE_CS;
        FB_RW     = IDLE_RW;
        ad_oe     = 1'b0;
        ad_out    = req_q.wdata;
        unique case (state)
            ST_IDLE: begin
                ready_c = 1'b1;
                if (req_valid)
                    state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                FB_ALE    = 1'b1;
                FB_CS     = 1'b1;
                FB_RW     = req_q.rw;
                ad_oe     = 1'b1;
                ad_out    = req_q.addr;
                state_nxt = ST_DATA;
            end
            ST_DATA: begin
                FB_CS  = 1'b0;
                FB_RW  = req_q.rw;
                ad_oe  = !req_q.rw;
                if (data_end)
                    state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                FB_CS     = 1'b1;
                FB_RW     = req_q.rw;
                rsp_c     = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bus is released in IDLE and HOLD so the slave gets a turnaround cycle
    assign FB_AD = ad_oe ? ad_out : 32'bz;

    // Ready is held low while reset is asserted
    assign req_ready = ready_c && !RST;
    assign rsp_valid = rsp_c;

    // Capture the request at acceptance
    always_ff @(posedge FB_CLK or posedge RST) begin
        if (RST)
            req_q <= '0;
        else if (accept)
            req_q <= '{rw: req_rw, addr: req_addr, wdata: req_wdata};
    end

    // Read data sampled at the edge closing the data phase; kept otherwise
    always_ff @(posedge FB_CLK or posedge RST) begin
        if (RST)
            rsp_rdata <= '0;
        else if (data_end && req_q.rw && !timeout)
            rsp_rdata <= FB_AD;
    end

`ifdef FLEXBUS_MASTER_TA_EN
    logic err_q;

    // Remember whether the data phase ended by timeout
    always_ff @(posedge FB_CLK or posedge RST) begin
        if (RST)
            err_q <= 1'b0;
        else if (data_end)
            err_q <= timeout;
    end

    assign rsp_err = err_q && (state == ST_HOLD);
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_flexbus_master.sv
// Bench for flexbus_master: directed and random transfers against a cycle-level
// expectation derived from the transfer rules (ADDR, N data cycles, HOLD).
module tb_flexbus_master;

    localparam int          WS   = 1;
    localparam int          TO   = 4;
    localparam logic [31:0] ZBUS = 32'hFFFF_FFFF;   // released bus reads as pulled-up

    logic        FB_CLK    = 1'b0;
    logic        RST       = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_rw    = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    wire         req_ready, rsp_valid, rsp_err, FB_ALE, FB_CS, FB_RW;
    wire  [31:0] rsp_rdata;
    wire  [31:0] FB_AD;
    logic        slv_oe    = 1'b0;
    logic [31:0] slv_data  = '0;
`ifdef FLEXBUS_MASTER_TA_EN
    logic        FB_TA     = 1'b1;
`endif

    int          n_tests   = 0;
    int          n_fail    = 0;
    int          cyc       = 0;
    logic [31:0] exp_rdata = '0;

    pullup pu_ad (FB_AD);
    assign FB_AD = slv_oe ? slv_data : 32'bz;

    flexbus_master #(.WAIT_STATES(WS), .TA_TIMEOUT(TO)) dut (
        .FB_CLK    (FB_CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .FB_ALE    (FB_ALE),
        .FB_CS     (FB_CS),
        .FB_RW     (FB_RW),
        .FB_AD     (FB_AD)
`ifdef FLEXBUS_MASTER_TA_EN
        ,
        .FB_TA     (FB_TA)
`endif
    );

    always #5 FB_CLK = ~FB_CLK;
    always @(posedge FB_CLK) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rnd32();
        logic [31:0] v;
        v = $urandom;
        if (v == ZBUS) v = 32'h0BAD_F00D;
        return v;
    endfunction

    // One transfer. ta_cyc: data cycle on which the slave acknowledges
    // (outside 1..TO means never); ignored in the fixed-length build.
    task automatic xfer(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdat, input int ta_cyc);
        int   nd;
        logic err;
`ifdef FLEXBUS_MASTER_TA_EN
        if (ta_cyc >= 1 && ta_cyc <= TO) begin nd = ta_cyc; err = 1'b0; end
        else begin nd = TO; err = 1'b1; end
`else
        nd  = 1 + WS;
        err = 1'b0;
        if (ta_cyc < 0) nd = 0;
`endif
        @(negedge FB_CLK);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge FB_CLK);
        chk("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wdata;
        @(negedge FB_CLK);
        req_valid = 1'b0; req_addr = rnd32(); req_wdata = rnd32(); req_rw = ~rw;
        chk("addr_ale", 32'(FB_ALE), 32'd1);
        chk("addr_cs", 32'(FB_CS), 32'd1);
        chk("addr_rw", 32'(FB_RW), 32'(rw));
        chk("addr_ad", FB_AD, addr);
        chk("addr_ready", 32'(req_ready), 32'd0);
        for (int k = 1; k <= nd; k++) begin
            @(negedge FB_CLK);
            chk("data_ale", 32'(FB_ALE), 32'd0);
            chk("data_cs", 32'(FB_CS), 32'd0);
            chk("data_rw", 32'(FB_RW), 32'(rw));
            chk("data_ad", FB_AD, rw ? ZBUS : wdata);
            chk("data_rspv", 32'(rsp_valid), 32'd0);
            if (k == nd) begin
                slv_oe = rw; slv_data = rdat;
`ifdef FLEXBUS_MASTER_TA_EN
                if (!err) FB_TA = 1'b0;
`endif
            end
        end
        @(negedge FB_CLK);
        slv_oe = 1'b0;
`ifdef FLEXBUS_MASTER_TA_EN
        FB_TA = 1'b1;
`endif
        #1;
        if (rw && !err) exp_rdata = rdat;
        chk("hold_rspv", 32'(rsp_valid), 32'd1);
        chk("hold_err", 32'(rsp_err), 32'(err));
        chk("hold_cs", 32'(FB_CS), 32'd1);
        chk("hold_ale", 32'(FB_ALE), 32'd0);
        chk("hold_rw", 32'(FB_RW), 32'(rw));
        chk("hold_ad", FB_AD, ZBUS);
        chk("hold_rdata", rsp_rdata, exp_rdata);
        @(negedge FB_CLK);
        chk("idle_rspv", 32'(rsp_valid), 32'd0);
        chk("idle_ready", 32'(req_ready), 32'd1);
        chk("idle_cs", 32'(FB_CS), 32'd1);
        chk("idle_rw", 32'(FB_RW), 32'd1);
        chk("idle_ad", FB_AD, ZBUS);
        chk("idle_rdata", rsp_rdata, exp_rdata);
    endtask

    initial begin
        int acc[$];
        int period;
        int nrsp;

        // Reset values
        #2;
        chk("rst_ale", 32'(FB_ALE), 32'd0);
        chk("rst_cs", 32'(FB_CS), 32'd1);
        chk("rst_rw", 32'(FB_RW), 32'd1);
        chk("rst_ad", FB_AD, ZBUS);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rspv", 32'(rsp_valid), 32'd0);
        chk("rst_err", 32'(rsp_err), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        repeat (2) @(negedge FB_CLK);
        RST = 1'b0;
        #1;
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        // Directed write and read
        xfer(1'b0, 32'h6000_0004, 32'h1234_5678, 32'h0, 2);
        xfer(1'b1, 32'h6000_0008, 32'h0, 32'hDEAD_BEEF, 2);
`ifdef FLEXBUS_MASTER_TA_EN
        xfer(1'b1, 32'h6000_000C, 32'h0, 32'hCAFE_0001, 3);
        xfer(1'b1, 32'h6000_0010, 32'h0, 32'h5555_AAAA, 0);
        xfer(1'b0, 32'h6000_0014, 32'hA5A5_0F0F, 32'h0, 0);
`endif

        // Random transfers
        for (int t = 0; t < 24; t++)
            xfer(1'($urandom_range(0, 1)), rnd32(), rnd32(), rnd32(), int'($urandom_range(1, TO + 1)));

        // Back-to-back requests: fixed accept period, bus released in HOLD
`ifdef FLEXBUS_MASTER_TA_EN
        FB_TA  = 1'b0;
        period = 4;
`else
        period = 4 + WS;
`endif
        @(negedge FB_CLK);
        req_valid = 1'b1; req_rw = 1'b0;
        for (int c = 0; c < 40; c++) begin
            req_addr = rnd32(); req_wdata = rnd32();
            #1;
            if (req_valid && req_ready) acc.push_back(cyc);
            if (rsp_valid) chk("b2b_hold_ad", FB_AD, ZBUS);
            @(negedge FB_CLK);
        end
        req_valid = 1'b0;
        repeat (10) @(negedge FB_CLK);
`ifdef FLEXBUS_MASTER_TA_EN
        FB_TA = 1'b1;
`endif
        chk("b2b_count", 32'(acc.size()), 32'((40 + period - 1) / period));
        for (int i = 1; i < acc.size(); i++)
            chk("b2b_period", 32'(acc[i] - acc[i-1]), 32'(period));

        // Reset in the second data cycle of a write
        @(negedge FB_CLK);
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge FB_CLK);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 32'h6000_0020; req_wdata = 32'h0F0F_1234;
        @(negedge FB_CLK);
        req_valid = 1'b0;
        repeat (2) @(negedge FB_CLK);
        chk("pre_rst_cs", 32'(FB_CS), 32'd0);
        RST = 1'b1;
        #1;
        exp_rdata = '0;
        chk("mid_rst_cs", 32'(FB_CS), 32'd1);
        chk("mid_rst_ad", FB_AD, ZBUS);
        chk("mid_rst_ale", 32'(FB_ALE), 32'd0);
        chk("mid_rst_rspv", 32'(rsp_valid), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_rdata", rsp_rdata, exp_rdata);
        @(negedge FB_CLK);
        RST = 1'b0;
        #1;
        chk("ready_after_rst2", 32'(req_ready), 32'd1);
        nrsp = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge FB_CLK);
            if (rsp_valid) nrsp++;
        end
        chk("aborted_no_rsp", 32'(nrsp), 32'd0);
        xfer(1'b1, 32'h6000_0024, 32'h0, 32'h7777_1111, 2);
        xfer(1'b0, 32'h6000_0028, 32'h2468_ACE0, 32'h0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
